// File: rtl/udp_packet_builder.sv
// UDP transmit framer: 8-byte header (checksum 0) then payload. UDP_TX_PAD_EN zero-pads short payloads.
// Latency: first header byte valid the cycle after an accepted start; payload in->out is 1 cycle.
// Backpressure: registered output byte holds while ready_in is low; payload_ready_out only when the output can advance.
module udp_packet_builder #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int ZERO_LEN_OK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        done,
    output logic        len_err,
    input  logic [7:0]  payload_data_in,
    input  logic        payload_valid_in,
    input  logic        payload_last_in,
    output logic        payload_ready_out,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    output logic        data_last_out,
    input  logic        ready_in
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

`ifdef UDP_TX_PAD_EN
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] remain_q, remain_d;
    logic [15:0] src_q, dst_q, len_q;
    logic [15:0] udp_len;
    logic        out_free, tail, last_hs, gen_en, start_ok, pay_take, final_byte;
    logic        ld, ld_last, err, fin;
    logic [7:0]  ld_dat, hdr_byte;

    assign udp_len           = len_q + 16'd8;
    assign out_free          = !data_valid_out || ready_in;
    // Once the last byte sits in the output register, generation stops until it drains.
    assign tail              = data_valid_out && data_last_out;
    assign last_hs           = tail && ready_in;
    assign gen_en            = out_free && !tail;
    assign start_ok          = (payload_len <= MAX_LEN) && ((ZERO_LEN_OK != 0) || (payload_len != 16'd0));
    assign final_byte        = (remain_q == 16'd1);
    assign busy              = (state_q != IDLE);
    assign payload_ready_out = (state_q == PAYLOAD) && gen_en;
    assign pay_take          = payload_ready_out && payload_valid_in;

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = udp_len[15:8];
            3'd5:    hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        remain_d  = remain_q;
        ld        = 1'b0;
        ld_dat    = 8'h00;
        ld_last   = 1'b0;
        err       = 1'b0;
        fin       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        // First header byte comes straight from the port so it is valid next cycle.
                        state_d   = HEADER;
                        hdr_idx_d = 3'd1;
                        remain_d  = payload_len;
                        ld        = 1'b1;
                        ld_dat    = src_port[15:8];
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (last_hs) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end else if (gen_en) begin
                    ld        = 1'b1;
                    ld_dat    = hdr_byte;
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'd7) begin
                        ld_last = (len_q == 16'd0);
                        if (len_q != 16'd0)
                            state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (last_hs) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end else if (pay_take) begin
                    ld       = 1'b1;
                    ld_dat   = payload_data_in;
                    remain_d = remain_q - 16'd1;
                    if (final_byte) begin
                        ld_last = 1'b1;
                        err     = !payload_last_in;
                    end else if (payload_last_in) begin
                        err = 1'b1;
`ifdef UDP_TX_PAD_EN
                        state_d = PAD;
`else
                        ld_last = 1'b1;
`endif
                    end
                end
            end
`ifdef UDP_TX_PAD_EN
            PAD: begin
                if (last_hs) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end else if (gen_en) begin
                    ld       = 1'b1;
                    ld_dat   = 8'h00;
                    ld_last  = final_byte;
                    remain_d = remain_q - 16'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            hdr_idx_q      <= 3'd0;
            remain_q       <= 16'd0;
            src_q          <= 16'd0;
            dst_q          <= 16'd0;
            len_q          <= 16'd0;
            done           <= 1'b0;
            len_err        <= 1'b0;
            data_out       <= 8'h00;
            data_valid_out <= 1'b0;
            data_last_out  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            remain_q  <= remain_d;
            done      <= fin;
            len_err   <= err;
            if (state_q == IDLE && start && start_ok) begin
                src_q <= src_port;
                dst_q <= dst_port;
                len_q <= payload_len;
            end
            if (ld) begin
                data_out       <= ld_dat;
                data_valid_out <= 1'b1;
                data_last_out  <= ld_last;
            end else if (ready_in) begin
                data_valid_out <= 1'b0;
                data_last_out  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_udp_packet_builder.sv
// Randomized bench for udp_packet_builder: a queue-based datagram model is checked on every output handshake.
module tb_udp_packet_builder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_port, dst_port, payload_len;
    logic        busy, done, len_err;
    logic [7:0]  payload_data_in;
    logic        payload_valid_in, payload_last_in, payload_ready_out;
    logic [7:0]  data_out;
    logic        data_valid_out, data_last_out;
    logic        ready_in;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ub_t;

    ub_t up_q[$];
    ub_t exp_q[$];
    ub_t last_model[$];
    int  hs_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0, done_cnt = 0, err_cnt = 0, pay_cnt = 0;
    int rdy_mode = 0, vld_mode = 0;
    bit pay_hs = 0, prev_stall = 0, prev_last_hs = 0, prev_last = 0;
    logic [7:0] prev_dat = 8'h00;

    localparam int MAXP = 1472;

    udp_packet_builder dut (
        .clk(clk), .rst(rst), .start(start),
        .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
        .busy(busy), .done(done), .len_err(len_err),
        .payload_data_in(payload_data_in), .payload_valid_in(payload_valid_in),
        .payload_last_in(payload_last_in), .payload_ready_out(payload_ready_out),
        .data_out(data_out), .data_valid_out(data_valid_out), .data_last_out(data_last_out),
        .ready_in(ready_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: samples mid-cycle, compares every handshake against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 0;
            prev_last_hs = 0;
            pay_hs       = 0;
        end else begin
            chk("done_after_last_hs", done, prev_last_hs);
            if (done) begin
                done_cnt++;
                chk("busy_low_with_done", busy, 1'b0);
            end
            if (len_err) err_cnt++;
            if (prev_stall) begin
                chk("stall_valid", data_valid_out, 1'b1);
                chk("stall_data", data_out, prev_dat);
                chk("stall_last", data_last_out, prev_last);
            end
            if (data_valid_out && !ready_in) chk("pready_while_stalled", payload_ready_out, 1'b0);
            if (!busy) chk("pready_while_idle", payload_ready_out, 1'b0);
            if (data_valid_out && ready_in) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    ub_t e;
                    e = exp_q.pop_front();
                    chk("out_byte", data_out, e.d);
                    chk("out_last", data_last_out, e.l);
                end
            end
            prev_last_hs = data_valid_out && ready_in && data_last_out;
            prev_stall   = data_valid_out && !ready_in;
            prev_dat     = data_out;
            prev_last    = data_last_out;
            pay_hs       = payload_valid_in && payload_ready_out;
            if (pay_hs) pay_cnt++;
        end
    end

    // Downstream ready and upstream payload source, driven just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = !ready_in;
            default: ready_in = ($urandom_range(0, 2) != 0);
        endcase
        if (pay_hs && up_q.size() > 0) void'(up_q.pop_front());
        pay_hs = 0;
        if (up_q.size() > 0 && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
            payload_valid_in = 1'b1;
            payload_data_in  = up_q[0].d;
            payload_last_in  = up_q[0].l;
        end else begin
            payload_valid_in = 1'b0;
            payload_data_in  = 8'h00;
            payload_last_in  = 1'b0;
        end
    end

    // Model: datagram = header(src,dst,len+8,0) + payload, truncated or padded when upstream last is early.
    task automatic setup_frame(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input int last_pos, input bit fixed, output bit ok, output bit ee);
        ub_t m[$];
        ub_t t;
        logic [7:0] pay[$];
        logic [7:0] hdr[8];
        logic [15:0] ulen;
        int li, n_up, ncopy;
        li   = int'(l);
        ok   = (li <= MAXP);
        ee   = !ok || (li != 0 && last_pos != li);
        ulen = l + 16'd8;
        hdr[0] = s[15:8]; hdr[1] = s[7:0]; hdr[2] = d[15:8]; hdr[3] = d[7:0];
        hdr[4] = ulen[15:8]; hdr[5] = ulen[7:0]; hdr[6] = 8'h00; hdr[7] = 8'h00;
        hs_cyc.delete();
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                t.d = hdr[i]; t.l = 1'b0; m.push_back(t);
            end
            n_up = (li == 0) ? 0 : last_pos;
            for (int i = 0; i < n_up; i++) begin
                t.d = fixed ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
                t.l = (i == n_up - 1);
                pay.push_back(t.d);
                up_q.push_back(t);
            end
            if (li > 0) begin
                ncopy = (last_pos < li) ? last_pos : li;
                for (int i = 0; i < ncopy; i++) begin
                    t.d = pay[i]; t.l = 1'b0; m.push_back(t);
                end
`ifdef UDP_TX_PAD_EN
                for (int i = ncopy; i < li; i++) begin
                    t.d = 8'h00; t.l = 1'b0; m.push_back(t);
                end
`endif
            end
            t = m.pop_back();
            t.l = 1'b1;
            m.push_back(t);
        end
        last_model = m;
        foreach (m[i]) exp_q.push_back(m[i]);
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        @(posedge clk);
        #1;
        start = 1'b1; src_port = s; dst_port = d; payload_len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                             input int last_pos, input bit fixed);
        bit ok, ee;
        int d0, e0, budget;
        d0 = done_cnt;
        e0 = err_cnt;
        setup_frame(s, d, l, last_pos, fixed, ok, ee);
        pulse_start(s, d, l);
        if (!ok) begin
            chk("reject_len_err", len_err, 1'b1);
            for (int i = 0; i < 3; i++) begin
                chk("reject_busy", busy, 1'b0);
                chk("reject_valid", data_valid_out, 1'b0);
                @(posedge clk);
                #1;
            end
        end else begin
            chk("first_busy", busy, 1'b1);
            chk("first_valid", data_valid_out, 1'b1);
            chk("first_byte", data_out, s[15:8]);
            budget = 0;
            while (done_cnt == d0 && budget < 8000) begin
                @(posedge clk);
                #1;
                budget++;
            end
            chk("frame_timeout", (done_cnt == d0) ? 32'd1 : 32'd0, 32'd0);
            repeat (2) @(posedge clk);
            #1;
        end
        chk("frame_bytes_left", exp_q.size(), 32'd0);
        chk("frame_done_count", done_cnt - d0, ok ? 32'd1 : 32'd0);
        chk("frame_len_err_count", err_cnt - e0, ee ? 32'd1 : 32'd0);
        exp_q.delete();
        up_q.delete();
    endtask

    logic [7:0] t1 [12];
    int p0, h0, d0r;
    bit ok6, ee6;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        t1 = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst = 1'b1; start = 1'b0; src_port = 16'h0; dst_port = 16'h0; payload_len = 16'h0;
        ready_in = 1'b0; payload_valid_in = 1'b0; payload_data_in = 8'h00; payload_last_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_valid", data_valid_out, 1'b0);
        chk("rst_last", data_last_out, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_pready", payload_ready_out, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame at full rate, model pinned to hand-computed bytes.
        run_frame(16'h1234, 16'h0050, 16'd4, 4, 1'b1);
        for (int i = 0; i < 12; i++) chk("t1_model_byte", last_model[i].d, t1[i]);
        chk("t1_model_last", last_model[11].l, 1'b1);
        chk("t1_out_count", hs_cyc.size(), 32'd12);
        if (hs_cyc.size() == 12) chk("t1_consecutive", hs_cyc[11] - hs_cyc[0], 32'd11);

        // Same frame with alternating ready.
        rdy_mode = 1;
        run_frame(16'h1234, 16'h0050, 16'd4, 4, 1'b1);
        rdy_mode = 0;

        // Header-only datagram.
        p0 = pay_cnt;
        run_frame(16'hC001, 16'h0007, 16'd0, 0, 1'b0);
        chk("t3_no_payload_taken", pay_cnt - p0, 32'd0);
        chk("t3_model_size", last_model.size(), 32'd8);
        chk("t3_model_len_lo", last_model[5].d, 8'h08);
        chk("t3_model_last", last_model[7].l, 1'b1);

        // Length limit.
        run_frame(16'h1111, 16'h2222, 16'd1473, 1473, 1'b0);
        run_frame(16'h3333, 16'h4444, 16'd1472, 1472, 1'b0);
        chk("t4_model_len_hi", last_model[4].d, 8'h05);
        chk("t4_model_len_lo", last_model[5].d, 8'hC8);

        // Short payload (last on 2nd of 4) and long payload (no last on 4th of 4).
        run_frame(16'h0102, 16'h0304, 16'd4, 2, 1'b1);
`ifdef UDP_TX_PAD_EN
        chk("t5_model_size", last_model.size(), 32'd12);
`else
        chk("t5_model_size", last_model.size(), 32'd10);
`endif
        run_frame(16'h0506, 16'h0708, 16'd4, 6, 1'b1);

        // Reset after three header bytes aborts the frame.
        setup_frame(16'hBEEF, 16'h0035, 16'd6, 6, 1'b0, ok6, ee6);
        h0  = hs_cnt;
        d0r = done_cnt;
        pulse_start(16'hBEEF, 16'h0035, 16'd6);
        for (int i = 0; i < 100 && hs_cnt < h0 + 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_hdr_bytes_before_rst", hs_cnt - h0, 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", data_valid_out, 1'b0);
        chk("t6_rst_data", data_out, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_pready", payload_ready_out, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        up_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0r, 32'd0);
        run_frame(16'hBEEF, 16'h0035, 16'd6, 6, 1'b0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            int len, lp, r;
            len = $urandom_range(0, 40);
            r   = $urandom_range(0, 9);
            if (len == 0)             lp = 0;
            else if (r == 0 && len > 1) lp = $urandom_range(1, len - 1);
            else if (r == 1)          lp = len + $urandom_range(1, 3);
            else                      lp = len;
            rdy_mode = $urandom_range(0, 2);
            vld_mode = $urandom_range(0, 1);
            run_frame(16'($urandom), 16'($urandom), 16'(len), lp, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
